// File: rtl/tri_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : tri_fifo_writer
// Purpose  : Producer end of the vertex/color FIFO pair feeding the
//            rasterizer's triangle register stage. Takes one whole triangle
//            (three vertices plus three per-vertex colors) through a
//            valid/ready handshake and writes it into both FIFOs in
//            lockstep, one vertex per cycle, in order 0, 1, 2.
// Ports    :
//   clk, rst_n                 clock, asynchronous active-low reset
//   tri_valid / tri_ready      triangle handshake from the transform stage
//   vertex_in0..2, color_in0..2  triangle payload (WIDTH bits each)
//   vertex_full, color_full    FIFO full flags
//   vertex_wr_en, vertex_din   vertex FIFO write port
//   color_wr_en,  color_din    color FIFO write port
//   busy                       a triangle is held and not fully written
//   tri_written                completed-triangle count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module tri_fifo_writer #(
  parameter int WIDTH = 96,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tri_valid,
  output logic             tri_ready,
  input  logic [WIDTH-1:0] vertex_in0,
  input  logic [WIDTH-1:0] vertex_in1,
  input  logic [WIDTH-1:0] vertex_in2,
  input  logic [WIDTH-1:0] color_in0,
  input  logic [WIDTH-1:0] color_in1,
  input  logic [WIDTH-1:0] color_in2,
  input  logic             vertex_full,
  input  logic             color_full,
  output logic             vertex_wr_en,
  output logic             color_wr_en,
  output logic [WIDTH-1:0] vertex_din,
  output logic [WIDTH-1:0] color_din,
  output logic             busy,
  output logic [CNT_W-1:0] tri_written
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2,
    WR2  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] v0_q, v1_q, v2_q, v0_d, v1_d, v2_d;
  logic [WIDTH-1:0] c0_q, c1_q, c2_q, c0_d, c1_d, c2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic w_wr_ok;
  logic w_ready;
  logic w_accept;
  logic w_wr_en;
  logic [WIDTH-1:0] w_vdin;
  logic [WIDTH-1:0] w_cdin;

  // --------------------------------------------------------------------------
  // Handshake. A triangle can be taken from IDLE, or in the WR2 cycle that is
  // actually writing the last vertex; that second case is what removes the
  // IDLE bubble between back-to-back triangles. Gating with rst_n keeps the
  // handshake dead while reset is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr_ok  = !vertex_full && !color_full;
    w_ready  = rst_n && ((state_q == IDLE) || ((state_q == WR2) && w_wr_ok));
    w_accept = tri_valid && w_ready;
  end

  // --------------------------------------------------------------------------
  // Next state, holding registers, counter and write port.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    cnt_d   = cnt_q;
    w_wr_en = 1'b0;
    // In IDLE the write data keeps showing the last entry written, which is
    // always vertex 2 (IDLE is only entered from WR2 or from reset, where
    // the holding registers are cleared).
    w_vdin  = v2_q;
    w_cdin  = c2_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      WR0: begin
        w_vdin  = v0_q;
        w_cdin  = c0_q;
        w_wr_en = w_wr_ok;
        if (w_wr_ok) state_d = WR1;
      end
      WR1: begin
        w_vdin  = v1_q;
        w_cdin  = c1_q;
        w_wr_en = w_wr_ok;
        if (w_wr_ok) state_d = WR2;
      end
      WR2: begin
        w_vdin  = v2_q;
        w_cdin  = c2_q;
        w_wr_en = w_wr_ok;
        if (w_wr_ok) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture overrides the WR2 -> IDLE transition for back-to-back flow.
    // The outgoing vertex 2 is still on the write port this cycle; the new
    // payload only lands in the holding registers at the clock edge.
    if (w_accept) begin
      state_d = WR0;
      v0_d    = vertex_in0;
      v1_d    = vertex_in1;
      v2_d    = vertex_in2;
      c0_d    = color_in0;
      c1_d    = color_in1;
      c2_d    = color_in2;
    end
  end

  // --------------------------------------------------------------------------
  // State and data registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Both FIFOs share one strobe so entry N of each always belongs to
  // the same vertex; the rst_n gate drops the strobes the moment reset is
  // asserted rather than waiting for the state register to settle.
  // --------------------------------------------------------------------------
  assign tri_ready    = w_ready;
  assign vertex_wr_en = rst_n && w_wr_en;
  assign color_wr_en  = rst_n && w_wr_en;
  assign vertex_din   = w_vdin;
  assign color_din    = w_cdin;
  assign busy         = rst_n && (state_q != IDLE);
  assign tri_written  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tri_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_fifo_writer
// Purpose  : Directed self-checking bench for tri_fifo_writer. A second
//            instance with a 3-bit counter exercises the counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tri_fifo_writer;

  localparam int WIDTH = 96;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             tri_valid;
  logic             tri_ready;
  logic [WIDTH-1:0] vertex_in0, vertex_in1, vertex_in2;
  logic [WIDTH-1:0] color_in0, color_in1, color_in2;
  logic             vertex_full, color_full;
  logic             vertex_wr_en, color_wr_en;
  logic [WIDTH-1:0] vertex_din, color_din;
  logic             busy;
  logic [CNT_W-1:0] tri_written;

  logic             w_valid;
  logic             w_ready;
  logic             w_vwr, w_cwr;
  logic [WIDTH-1:0] w_vdin, w_cdin;
  logic             w_busy;
  logic [2:0]       w_cnt;

  int n_vec = 0;
  int n_err = 0;

  tri_fifo_writer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tri_valid    (tri_valid),
    .tri_ready    (tri_ready),
    .vertex_in0   (vertex_in0),
    .vertex_in1   (vertex_in1),
    .vertex_in2   (vertex_in2),
    .color_in0    (color_in0),
    .color_in1    (color_in1),
    .color_in2    (color_in2),
    .vertex_full  (vertex_full),
    .color_full   (color_full),
    .vertex_wr_en (vertex_wr_en),
    .color_wr_en  (color_wr_en),
    .vertex_din   (vertex_din),
    .color_din    (color_din),
    .busy         (busy),
    .tri_written  (tri_written)
  );

  tri_fifo_writer #(.WIDTH(WIDTH), .CNT_W(3)) dut_wrap (
    .clk          (clk),
    .rst_n        (rst_n),
    .tri_valid    (w_valid),
    .tri_ready    (w_ready),
    .vertex_in0   (vertex_in0),
    .vertex_in1   (vertex_in1),
    .vertex_in2   (vertex_in2),
    .color_in0    (color_in0),
    .color_in1    (color_in1),
    .color_in2    (color_in2),
    .vertex_full  (1'b0),
    .color_full   (1'b0),
    .vertex_wr_en (w_vwr),
    .color_wr_en  (w_cwr),
    .vertex_din   (w_vdin),
    .color_din    (w_cdin),
    .busy         (w_busy),
    .tri_written  (w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] pat(input logic [7:0] b);
    return {b, 80'h0123_4567_89AB_CDEF_5A5A, b};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tri(input logic [7:0] vb, input logic [7:0] cb);
    vertex_in0 = pat(vb);
    vertex_in1 = pat(vb + 8'd1);
    vertex_in2 = pat(vb + 8'd2);
    color_in0  = pat(cb);
    color_in1  = pat(cb + 8'd1);
    color_in2  = pat(cb + 8'd2);
  endtask

  // Settle, then compare every output of the main instance for this cycle.
  task automatic exp_out(input string tag, input logic wr,
                         input logic [WIDTH-1:0] vd, input logic [WIDTH-1:0] cd,
                         input logic rdy, input logic bsy,
                         input logic [CNT_W-1:0] cnt);
    #1;
    check_eq({tag, ".vwr"},  {127'd0, vertex_wr_en}, {127'd0, wr});
    check_eq({tag, ".cwr"},  {127'd0, color_wr_en},  {127'd0, wr});
    check_eq({tag, ".vdin"}, {32'd0, vertex_din},    {32'd0, vd});
    check_eq({tag, ".cdin"}, {32'd0, color_din},     {32'd0, cd});
    check_eq({tag, ".rdy"},  {127'd0, tri_ready},    {127'd0, rdy});
    check_eq({tag, ".busy"}, {127'd0, busy},         {127'd0, bsy});
    check_eq({tag, ".cnt"},  {112'd0, tri_written},  {112'd0, cnt});
  endtask

  initial begin
    rst_n       = 1'b0;
    tri_valid   = 1'b1;
    w_valid     = 1'b0;
    vertex_full = 1'b0;
    color_full  = 1'b0;
    set_tri(8'hA0, 8'hC0);

    // Reset: everything quiet even with a triangle offered.
    #2;
    exp_out("reset", 0, '0, '0, 0, 0, 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_out("idle_a", 0, '0, '0, 1, 0, 0);

    // Single triangle, FIFOs never full.
    cyc(); tri_valid = 1'b0;
    exp_out("a_wr0", 1, pat(8'hA0), pat(8'hC0), 0, 1, 0);
    cyc(); exp_out("a_wr1", 1, pat(8'hA1), pat(8'hC1), 0, 1, 0);
    cyc(); exp_out("a_wr2", 1, pat(8'hA2), pat(8'hC2), 1, 1, 0);
    cyc(); tri_valid = 1'b1; set_tri(8'h10, 8'h14);
    exp_out("a_idle", 0, pat(8'hA2), pat(8'hC2), 1, 0, 1);

    // Two triangles back to back with tri_valid held.
    cyc(); set_tri(8'h18, 8'h1C);
    exp_out("b_wr0", 1, pat(8'h10), pat(8'h14), 0, 1, 1);
    cyc(); exp_out("b_wr1", 1, pat(8'h11), pat(8'h15), 0, 1, 1);
    cyc(); exp_out("b_wr2", 1, pat(8'h12), pat(8'h16), 1, 1, 1);
    cyc(); tri_valid = 1'b0;
    exp_out("t2_wr0", 1, pat(8'h18), pat(8'h1C), 0, 1, 2);
    cyc(); exp_out("t2_wr1", 1, pat(8'h19), pat(8'h1D), 0, 1, 2);
    cyc(); exp_out("t2_wr2", 1, pat(8'h1A), pat(8'h1E), 1, 1, 2);
    cyc(); tri_valid = 1'b1; set_tri(8'h40, 8'h44);
    exp_out("t2_idle", 0, pat(8'h1A), pat(8'h1E), 1, 0, 3);

    // vertex_full held for 4 cycles during WR1.
    cyc(); tri_valid = 1'b0;
    exp_out("e_wr0", 1, pat(8'h40), pat(8'h44), 0, 1, 3);
    for (int i = 0; i < 4; i++) begin
      cyc(); vertex_full = 1'b1;
      exp_out("e_stall", 0, pat(8'h41), pat(8'h45), 0, 1, 3);
    end
    cyc(); vertex_full = 1'b0;
    exp_out("e_wr1", 1, pat(8'h41), pat(8'h45), 0, 1, 3);
    cyc(); exp_out("e_wr2", 1, pat(8'h42), pat(8'h46), 1, 1, 3);
    cyc(); tri_valid = 1'b1; set_tri(8'h60, 8'h64);
    exp_out("e_idle", 0, pat(8'h42), pat(8'h46), 1, 0, 4);

    // color_full throughout WR2 while the next triangle is offered.
    cyc(); tri_valid = 1'b0;
    exp_out("f_wr0", 1, pat(8'h60), pat(8'h64), 0, 1, 4);
    cyc(); exp_out("f_wr1", 1, pat(8'h61), pat(8'h65), 0, 1, 4);
    for (int i = 0; i < 3; i++) begin
      cyc(); color_full = 1'b1; tri_valid = 1'b1; set_tri(8'h80, 8'h84);
      exp_out("f_stall", 0, pat(8'h62), pat(8'h66), 0, 1, 4);
    end
    cyc(); color_full = 1'b0;
    exp_out("f_wr2", 1, pat(8'h62), pat(8'h66), 1, 1, 4);
    cyc(); tri_valid = 1'b0;
    exp_out("g_wr0", 1, pat(8'h80), pat(8'h84), 0, 1, 5);
    cyc(); exp_out("g_wr1", 1, pat(8'h81), pat(8'h85), 0, 1, 5);
    cyc(); exp_out("g_wr2", 1, pat(8'h82), pat(8'h86), 1, 1, 5);
    cyc(); tri_valid = 1'b1; set_tri(8'hE0, 8'hE4);
    exp_out("g_idle", 0, pat(8'h82), pat(8'h86), 1, 0, 6);

    // Reset pulsed mid-WR1: partial triangle dropped at once.
    cyc(); tri_valid = 1'b0;
    exp_out("h_wr0", 1, pat(8'hE0), pat(8'hE4), 0, 1, 6);
    cyc(); exp_out("h_wr1", 1, pat(8'hE1), pat(8'hE5), 0, 1, 6);
    rst_n = 1'b0;
    exp_out("h_rst", 0, '0, '0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    exp_out("h_rel", 0, '0, '0, 1, 0, 0);
    cyc(); exp_out("h_after", 0, '0, '0, 1, 0, 0);

    // Counter wrap on the 3-bit instance: eight triangles back to back.
    cyc(); w_valid = 1'b1; set_tri(8'h33, 8'h77);
    #1;
    check_eq("wrap.rdy", {127'd0, w_ready}, 128'd1);
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 3; k++) begin
        cyc();
        if (t == 7 && k == 0) w_valid = 1'b0;
        #1;
        if (k == 0) check_eq("wrap.cnt", {125'd0, w_cnt}, {125'd0, 3'(t)});
        check_eq("wrap.wr", {126'd0, w_vwr, w_cwr}, 128'd3);
      end
    end
    cyc();
    #1;
    check_eq("wrap.final", {125'd0, w_cnt}, 128'd0);
    check_eq("wrap.busy", {127'd0, w_busy}, 128'd0);
    check_eq("wrap.main_cnt", {112'd0, tri_written}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
